// File: rtl/mem_model_pkg.sv
// Shared types and constants for the queued line memory model.
//   mem_req_t      : one queued request {rw, addr, wdata, be}
//   engine_state_e : access engine states
//   LINE_OFF_W     : byte-offset bits within a line
package mem_model_pkg;

  localparam int unsigned MEM_ADDR_W     = 32;
  localparam int unsigned MEM_LINE_BYTES = 64;
  localparam int unsigned MEM_DATA_W     = 8 * MEM_LINE_BYTES;
  localparam int unsigned LINE_OFF_W     = $clog2(MEM_LINE_BYTES);

  typedef struct packed {
    logic                      rw;
    logic [MEM_ADDR_W-1:0]     addr;
    logic [MEM_DATA_W-1:0]     wdata;
    logic [MEM_LINE_BYTES-1:0] be;
  } mem_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } engine_state_e;

endpackage

// File: rtl/mem_model_queued_sync_fifo.sv
// Request FIFO holding mem_req_t entries, head visible combinationally.
//   clk, rst            : clock, synchronous active-high reset (empties FIFO)
//   push, push_data     : write an entry (ignored when full)
//   pop, pop_data       : drop the head entry (ignored when empty); pop_data is the head
//   full, empty, count  : occupancy, derived from the registered count
module sync_fifo
  import mem_model_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  mem_req_t         push_data,
  input  logic             pop,
  output mem_req_t         pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  mem_req_t         store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = store_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_model_queued.sv
// Line-granular backing memory with an in-order request queue and fixed latency.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake; ready = queue not full
//   req_rw, req_addr        : 1 = write; byte address (line offset ignored)
//   req_wdata, req_be       : write line and per-byte enables
//   resp_valid              : one-cycle response pulse, strictly in request order
//   resp_rw, resp_rdata     : echoed type; read data (0 for writes and errors)
//   resp_err                : line index beyond DEPTH_LINES
module mem_model_queued
  import mem_model_pkg::*;
#(
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned LINE_BYTES  = MEM_LINE_BYTES,
  parameter int unsigned DEPTH_LINES = 16,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*LINE_BYTES-1:0] req_wdata,
  input  logic [LINE_BYTES-1:0]   req_be,
  output logic                    resp_valid,
  output logic                    resp_rw,
  output logic [8*LINE_BYTES-1:0] resp_rdata,
  output logic                    resp_err
);

  localparam int unsigned DATA_W = 8 * LINE_BYTES;
  localparam int unsigned CNT_W  = $clog2(LATENCY);
  localparam int unsigned LINE_W = MEM_ADDR_W - LINE_OFF_W;
  localparam int unsigned IDX_W  = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int unsigned QCNT_W = $clog2(QUEUE_DEPTH) + 1;

  // Backing store: intentionally not reset so contents survive rst.
  logic [MEM_DATA_W-1:0] mem [DEPTH_LINES];

  mem_req_t            push_req, head_req;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [QCNT_W-1:0]   unused_fifo_count;

  engine_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  mem_req_t            cur_q, cur_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_rw_q, resp_rw_d;
  logic [MEM_DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                mem_we;

  logic [LINE_W-1:0]   cur_line;
  logic                cur_in_range;
  logic [IDX_W-1:0]    cur_idx;
  logic                unused_addr_off;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;

  always_comb begin
    push_req.rw    = req_rw;
    push_req.addr  = MEM_ADDR_W'(req_addr);
    push_req.wdata = MEM_DATA_W'(req_wdata);
    push_req.be    = MEM_LINE_BYTES'(req_be);
  end

  sync_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (QCNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  // Full line index is compared, so high address bits never alias into the array.
  assign cur_line        = cur_q.addr[MEM_ADDR_W-1:LINE_OFF_W];
  assign cur_in_range    = (cur_line < LINE_W'(DEPTH_LINES));
  assign cur_idx         = IDX_W'(cur_line);
  assign unused_addr_off = ^cur_q.addr[LINE_OFF_W-1:0];

  // Engine: pop from IDLE, count down LATENCY-2, respond and chain the next pop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    fifo_pop     = 1'b0;
    mem_we       = 1'b0;
    resp_valid_d = 1'b0;
    resp_rw_d    = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = head_req;
          cnt_d    = CNT_W'(LATENCY - 2);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          resp_valid_d = 1'b1;
          resp_rw_d    = cur_q.rw;
          resp_err_d   = !cur_in_range;
          if (!cur_q.rw && cur_in_range) resp_rdata_d = mem[cur_idx];
          mem_we = cur_q.rw && cur_in_range;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = head_req;
            cnt_d    = CNT_W'(LATENCY - 2);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rw_q    <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      resp_valid_q <= resp_valid_d;
      resp_rw_q    <= resp_rw_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Byte-masked write; suppressed under reset so a discarded write never commits.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < int'(MEM_LINE_BYTES); b++) begin
        if (cur_q.be[b]) mem[cur_idx][8*b +: 8] <= cur_q.wdata[8*b +: 8];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rw    = resp_rw_q;
  assign resp_rdata = DATA_W'(resp_rdata_q);
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_model_queued.sv
// Self-checking bench for mem_model_queued with a line-array reference model.
module tb_mem_model_queued;

  localparam int LB  = 64;
  localparam int DW  = 8 * LB;
  localparam int NL  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic [LB-1:0] req_be;
  logic          resp_valid;
  logic          resp_rw;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  mem_model_queued dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_rw    (resp_rw),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          rw;
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
  } got_t;

  typedef struct {
    bit          rw;
    bit          err;
    bit [DW-1:0] rdata;
    int          acc;
  } exp_t;

  got_t got_q[$];
  exp_t exp_q[$];
  bit [DW-1:0] mdl [NL];
  int n_vec = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (resp_valid === 1'b1) got_q.push_back('{resp_rw, resp_err, resp_rdata, cyc});
  end

  // Reference: memory is an array of lines; a request resolves fully in issue order.
  function automatic exp_t model_apply(bit rw, bit [31:0] addr, bit [DW-1:0] wd, bit [LB-1:0] be);
    exp_t e;
    bit [31:0] line;
    line    = addr / LB;
    e.rw    = rw;
    e.err   = (line >= NL);
    e.rdata = '0;
    e.acc   = 0;
    if (!e.err) begin
      if (rw) begin
        for (int b = 0; b < LB; b++) if (be[b]) mdl[line][8*b +: 8] = wd[8*b +: 8];
      end else begin
        e.rdata = mdl[line];
      end
    end
    return e;
  endfunction

  function automatic bit [DW-1:0] rand_line();
    bit [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit [DW-1:0] fill_byte(bit [7:0] v);
    bit [DW-1:0] r;
    for (int i = 0; i < LB; i++) r[8*i +: 8] = v;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input bit rw, input bit [31:0] addr, input bit [DW-1:0] wd,
                      input bit [LB-1:0] be, output int acc);
    exp_t e;
    int waited;
    waited    = 0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout ready=%b required=1", req_ready);
      req_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      req_valid = 1'b0;
      e = model_apply(rw, addr, wd, be);
      e.acc = acc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_resp(input int n, output bit ok);
    int t;
    t = 0;
    while (got_q.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got=%b required=0", resp_valid); end
    n_vec++; if (resp_rw !== 1'b0) begin n_err++; $display("FAIL rst_resp_rw got=%b required=0", resp_rw); end
    n_vec++; if (resp_rdata !== '0) begin n_err++; $display("FAIL rst_resp_rdata got=%h required=0", resp_rdata); end
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err got=%b required=0", resp_err); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got=%b required=1", req_ready); end
    got_q.delete();
  endtask

  task automatic test_basic();
    int acc; bit ok; got_t g; exp_t e;
    for (int k = 0; k < 2; k++) begin
      send(k == 0, 32'h40, fill_byte(8'hA5), '1, acc);
      wait_resp(1, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL basic_timeout[%0d] got=0 required=1", k); end
      else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if ({g.rw, g.err, g.rdata} !== {e.rw, e.err, e.rdata}) begin
          n_err++; $display("FAIL basic_resp[%0d] got rw=%b err=%b rdata=%h required rw=%b err=%b rdata=%h", k, g.rw, g.err, g.rdata, e.rw, e.err, e.rdata);
        end
        n_vec++;
        if (g.cyc - e.acc != LAT) begin n_err++; $display("FAIL basic_latency[%0d] got=%0d required=%0d", k, g.cyc - e.acc, LAT); end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_byte_enable();
    int acc; bit ok; got_t g; exp_t e; bit [DW-1:0] d;
    bit [LB-1:0] be1;
    d = '0; d[7:0] = 8'hAA;
    be1 = '0; be1[0] = 1'b1;
    send(1'b1, 32'h80, fill_byte(8'hFF), '1, acc);
    send(1'b1, 32'h80, d, be1, acc);
    send(1'b0, 32'h80, '0, '0, acc);
    wait_resp(3, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL be_timeout got=%0d required=3", got_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (i > 0) n_vec++;
      if ({g.rw, g.err, g.rdata} !== {e.rw, e.err, e.rdata}) begin
        n_err++; $display("FAIL be_resp[%0d] got rw=%b err=%b rdata=%h required rw=%b err=%b rdata=%h", i, g.rw, g.err, g.rdata, e.rw, e.err, e.rdata);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_out_of_range();
    int acc; bit ok; got_t g; exp_t e; bit [DW-1:0] d;
    d = '0; d[15:0] = 16'h1234;
    send(1'b0, 32'h400, '0, '0, acc);
    send(1'b1, 32'h400, d, '1, acc);
    send(1'b0, 32'h000, '0, '0, acc);
    send(1'b0, 32'hFFFF_FFC0, '0, '0, acc);
    wait_resp(4, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL oor_timeout got=%0d required=4", got_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (i > 0) n_vec++;
      if ({g.rw, g.err, g.rdata} !== {e.rw, e.err, e.rdata}) begin
        n_err++; $display("FAIL oor_resp[%0d] got rw=%b err=%b rdata=%h required rw=%b err=%b rdata=%h", i, g.rw, g.err, g.rdata, e.rw, e.err, e.rdata);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int acc; bit ok; got_t g; exp_t e; int prev;
    for (int i = 0; i < 6; i++) send(1'b0, 32'(i * LB), '0, '0, acc);
    // Six pushes against two pops leaves four queued: the queue is full here.
    n_vec++;
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full got=%b required=0", req_ready); end
    wait_resp(6, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL b2b_timeout got=%0d required=6", got_q.size()); end
    else begin
      prev = 0;
      for (int i = 0; i < 6; i++) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (i > 0) n_vec++;
        if ({g.rw, g.err, g.rdata} !== {e.rw, e.err, e.rdata}) begin
          n_err++; $display("FAIL b2b_resp[%0d] got rw=%b err=%b rdata=%h required rw=%b err=%b rdata=%h", i, g.rw, g.err, g.rdata, e.rw, e.err, e.rdata);
        end
        if (i > 0) begin
          n_vec++;
          if (g.cyc - prev != LAT - 1) begin n_err++; $display("FAIL b2b_spacing[%0d] got=%0d required=%0d", i, g.cyc - prev, LAT - 1); end
        end
        prev = g.cyc;
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_offset();
    int acc; bit ok; got_t g; exp_t e;
    send(1'b1, 32'h47, fill_byte(8'h77), '1, acc);
    send(1'b0, 32'h40, '0, '0, acc);
    wait_resp(2, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL offset_timeout got=%0d required=2", got_q.size()); end
    else for (int i = 0; i < 2; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (i > 0) n_vec++;
      if ({g.rw, g.err, g.rdata} !== {e.rw, e.err, e.rdata}) begin
        n_err++; $display("FAIL offset_resp[%0d] got rw=%b err=%b rdata=%h required rw=%b err=%b rdata=%h", i, g.rw, g.err, g.rdata, e.rw, e.err, e.rdata);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int acc; bit ok; got_t g; exp_t e;
    got_q.delete(); exp_q.delete();
    // Three writes to line 2 that reset must discard; the model never sees them.
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h80;
      req_wdata = rand_line(); req_be = '1;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready got=%b required=1", req_ready); end
    repeat (12) @(negedge clk);
    n_vec++;
    if (got_q.size() != 0) begin n_err++; $display("FAIL rmid_no_resp got=%0d required=0", got_q.size()); end
    got_q.delete();
    send(1'b0, 32'h80, '0, '0, acc);
    wait_resp(1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rmid_timeout got=0 required=1"); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if ({g.rw, g.err, g.rdata} !== {e.rw, e.err, e.rdata}) begin
        n_err++; $display("FAIL rmid_read got rw=%b err=%b rdata=%h required rw=%b err=%b rdata=%h", g.rw, g.err, g.rdata, e.rw, e.err, e.rdata);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int acc; bit ok; got_t g; exp_t e; int n;
    bit [31:0] line;
    n = 40;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) line = $urandom_range(16, 32'h3FF_FFFF);
      else line = $urandom_range(0, NL - 1);
      send($urandom_range(0, 1) == 1, (line << 6) | 32'($urandom_range(0, LB - 1)),
           rand_line(), {$urandom, $urandom}, acc);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_resp(n, ok);
    if (!ok) begin n_vec++; n_err++; $display("FAIL rand_timeout got=%0d required=%0d", got_q.size(), n); end
    else for (int i = 0; i < n; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_vec++;
      if ({g.rw, g.err, g.rdata} !== {e.rw, e.err, e.rdata}) begin
        n_err++; $display("FAIL rand_resp[%0d] got rw=%b err=%b rdata=%h required rw=%b err=%b rdata=%h", i, g.rw, g.err, g.rdata, e.rw, e.err, e.rdata);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_offset();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
